data_sram_resp: RTL and testbench
=================================

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 10, meaning word-index width; memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT, default 1, meaning read wait states; legal range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 data_sram_en  input  1  request strobe from the CPU memory-access stage.
REQ-006 data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 is a read.
REQ-007 data_sram_addr  input  32  byte address.
REQ-008 data_sram_wdata  input  32  store data; byte i is bits 8i+7:8i.
REQ-009 data_sram_rdata  output  32  registered read data.
REQ-010 rvalid  output  1  high for exactly the one cycle in which rdata carries a new read result.
REQ-011 stallreq  output  1  registered stall request to the pipeline stall controller; high while a read is pending.

Function
REQ-012 Word index SHALL be addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 ignored (aliasing is legal).
REQ-013 FSM SHALL have states IDLE, BUSY, RESP; requests are accepted only in IDLE or RESP.
REQ-014 Write (en=1, wen!=0) accepted at edge T SHALL update only the enabled bytes at T; no wait states, no stallreq, no rvalid; state goes to or stays in IDLE.
REQ-015 Read (en=1, wen=0) accepted at edge T SHALL capture the index and a WAIT counter loaded with WAIT.
REQ-016 WAIT=0: state RESP in cycle after T; rdata=mem[index], rvalid=1, stallreq=0.
REQ-017 WAIT=N>0: state BUSY for N cycles after T with stallreq=1, counter decrementing each edge; on counter reaching 0 go RESP, rdata=mem[index] sampled at the BUSY->RESP edge, rvalid=1, stallreq=0.
REQ-018 RESP lasts one cycle; a request present in RESP SHALL be accepted (back-to-back); otherwise return to IDLE.
REQ-019 Requests (en, wen, addr, wdata) during BUSY SHALL be ignored; no memory write occurs in BUSY.
REQ-020 en=0 in IDLE/RESP: no operation; state goes to IDLE.
REQ-021 rdata SHALL hold its last value outside RESP; rvalid=0 outside RESP.
REQ-022 Read accepted the cycle after a write to the same word SHALL return the written data (write-then-read coherency, including partial bytes merged with old bytes).
REQ-023 Read of a never-written word returns the memory content; no X-suppression required beyond simulation initialisation to 0.

Reset
REQ-024 resetn low SHALL asynchronously force state=IDLE, counter=0, rdata=32'h0, rvalid=0, stallreq=0.
REQ-025 Reset asserted mid-BUSY SHALL abort the pending read; no rvalid is produced after release.
REQ-026 Memory array contents SHALL NOT be cleared by reset.
REQ-027 First request SHALL be accepted on the first rising edge with resetn high.

Verification
REQ-028 WAIT=0: write addr 0x10 wdata 0xDEADBEEF wen 4'hF, next cycle read 0x10 -> following cycle rdata=0xDEADBEEF, rvalid=1, stallreq never high.
REQ-029 WAIT=1: read 0x10 -> 1 cycle stallreq=1, next cycle rdata=0xDEADBEEF, rvalid=1; rdata unchanged during stall.
REQ-030 Partial write: mem[0x20]=0x11223344, write wen 4'b0101 wdata 0xAABBCCDD, read 0x20 -> 0x11BB33DD.
REQ-031 Aliasing (ADDR_W=10): write 0x0000_1004 data 0x5, read 0x0000_0004 -> 0x5; addr 0x0000_0007 reads same word.
REQ-032 WAIT=3: read issued, write request held during BUSY -> memory unchanged, rvalid after 4 cycles; then back-to-back reads in RESP accepted with no idle gap.
REQ-033 WAIT=2: assert resetn=0 in 2nd BUSY cycle -> stallreq, rvalid, rdata immediately 0; after release no rvalid without new request; prior memory data still readable.

Source files
------------

// File: rtl/data_sram_resp.sv
// Data SRAM with a CPU-side response FSM: single-cycle byte-masked writes, and
// reads that finish after WAIT wait states with a registered stall request.
module data_sram_resp #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rvalid,
  output logic        stallreq
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WAIT_L = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              stall_q, stall_d;

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] req_idx;
  logic              accept;
  logic              do_write;
  logic              do_read;
  logic              unused_addr_bits;

  // Upper address bits alias onto the same words; byte offset is ignored.
  assign req_idx          = data_sram_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

  assign accept   = data_sram_en && (state_q != BUSY);
  assign do_write = accept && (data_sram_wen != 4'b0000);
  assign do_read  = accept && (data_sram_wen == 4'b0000);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    case (state_q)
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          rdata_d = mem[idx_q];
        end
      end
      default: begin
        // IDLE and RESP both accept a new request; RESP thus allows back-to-back.
        state_d = IDLE;
        if (do_read) begin
          idx_d = req_idx;
          cnt_d = WAIT_L;
          if (WAIT_L == 4'd0) begin
            state_d = RESP;
            rdata_d = mem[req_idx];
          end else begin
            state_d = BUSY;
          end
        end
      end
    endcase
    rvalid_d = (state_d == RESP);
    stall_d  = (state_d == BUSY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
  end

  // Array is never reset so stored data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wen[b]) mem[req_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign rvalid          = rvalid_q;
  assign stallreq        = stall_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: four instances (WAIT=0..3) share one request bus;
// one instance at a time is scored against a queue of expected read data.
module tb_data_sram_resp;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_w [4];
  logic        rvalid_w [4];
  logic        stall_w [4];

  int          checks = 0;
  int          passed = 0;
  int          sel = 0;
  int          rv_seen = 0;
  int          stall_seen = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        rd;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [$];

  data_sram_resp #(.ADDR_W(10), .WAIT(0)) u_w0 (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata_w[0]), .rvalid(rvalid_w[0]), .stallreq(stall_w[0]));
  data_sram_resp #(.ADDR_W(10), .WAIT(1)) u_w1 (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata_w[1]), .rvalid(rvalid_w[1]), .stallreq(stall_w[1]));
  data_sram_resp #(.ADDR_W(10), .WAIT(2)) u_w2 (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata_w[2]), .rvalid(rvalid_w[2]), .stallreq(stall_w[2]));
  data_sram_resp #(.ADDR_W(10), .WAIT(3)) u_w3 (
    .clk(clk), .resetn(resetn), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata_w[3]), .rvalid(rvalid_w[3]), .stallreq(stall_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (dut WAIT=%0d, t=%0t)", nm, act, exp, sel, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en    = e;
    wen   = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic idle_n(input int n);
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (n) step();
  endtask

  // Scoreboard: every rvalid of the selected instance consumes one expected word.
  always @(negedge clk) begin
    if (rvalid_w[sel]) begin
      rv_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_rvalid: got rdata %h with no read pending (dut WAIT=%0d)", rdata_w[sel], sel);
      end else begin
        chk("scoreboard_rdata", rdata_w[sel], exp_q.pop_front());
      end
    end
    if (stall_w[sel]) stall_seen++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    int          rv_before;

    resetn = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) step();
    for (int d = 0; d < 4; d++) begin
      chk("reset_rdata", rdata_w[d], 32'h0);
      chk("reset_rvalid", {31'h0, rvalid_w[d]}, 32'h0);
      chk("reset_stall", {31'h0, stall_w[d]}, 32'h0);
    end
    resetn = 1'b1;

    // WAIT=0 instance: one request per cycle, first one on the first edge after release.
    sel = 0;
    stall_seen = 0;
    tbl.push_back('{1'b0, 4'hF, 32'h0000_0010, 32'hDEADBEEF, 32'h0});
    tbl.push_back('{1'b1, 4'h0, 32'h0000_0010, 32'h0,        32'hDEADBEEF});
    tbl.push_back('{1'b0, 4'hF, 32'h0000_0020, 32'h11223344, 32'h0});
    tbl.push_back('{1'b0, 4'h5, 32'h0000_0020, 32'hAABBCCDD, 32'h0});
    tbl.push_back('{1'b1, 4'h0, 32'h0000_0020, 32'h0,        32'h11BB33DD});
    tbl.push_back('{1'b0, 4'hF, 32'h0000_1004, 32'h0000_0005, 32'h0});
    tbl.push_back('{1'b1, 4'h0, 32'h0000_0004, 32'h0,        32'h0000_0005});
    tbl.push_back('{1'b1, 4'h0, 32'h0000_0007, 32'h0,        32'h0000_0005});
    tbl.push_back('{1'b0, 4'hF, 32'h0000_0030, 32'h0,        32'h0});
    tbl.push_back('{1'b0, 4'h8, 32'h0000_0030, 32'h99887766, 32'h0});
    tbl.push_back('{1'b1, 4'h0, 32'h0000_0030, 32'h0,        32'h9900_0000});
    tbl.push_back('{1'b0, 4'h3, 32'h0000_0032, 32'h0000_1234, 32'h0});
    tbl.push_back('{1'b1, 4'h0, 32'h0000_0031, 32'h0,        32'h9900_1234});
    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b1, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].rd) exp_q.push_back(tbl[i].exp);
      step();
    end
    idle_n(2);
    chk("w0_queue_drained", exp_q.size(), 32'h0);
    chk("w0_stall_never", stall_seen, 32'h0);
    idle_n(4);

    // WAIT=1: one stall cycle with rdata held, then the result.
    sel = 1;
    drive(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    step();
    prev = rdata_w[1];
    drive(1'b1, 4'h0, 32'h10, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    step();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    chk("w1_stall_on", {31'h0, stall_w[1]}, 32'h1);
    chk("w1_rvalid_off", {31'h0, rvalid_w[1]}, 32'h0);
    chk("w1_rdata_held", rdata_w[1], prev);
    step();
    chk("w1_stall_off", {31'h0, stall_w[1]}, 32'h0);
    chk("w1_rvalid_on", {31'h0, rvalid_w[1]}, 32'h1);
    idle_n(2);
    chk("w1_queue_drained", exp_q.size(), 32'h0);
    idle_n(4);

    // WAIT=3: writes during BUSY are dropped; RESP accepts the next read directly.
    sel = 3;
    drive(1'b1, 4'hF, 32'h40, 32'h12345678);
    step();
    drive(1'b1, 4'hF, 32'h44, 32'hA5A5A5A5);
    step();
    drive(1'b1, 4'h0, 32'h40, 32'h0);
    exp_q.push_back(32'h12345678);
    step();
    drive(1'b1, 4'hF, 32'h40, 32'hFFFFFFFF);
    for (int i = 0; i < 3; i++) begin
      chk("w3_busy_stall", {31'h0, stall_w[3]}, 32'h1);
      chk("w3_busy_rvalid", {31'h0, rvalid_w[3]}, 32'h0);
      step();
    end
    chk("w3_resp_rvalid", {31'h0, rvalid_w[3]}, 32'h1);
    chk("w3_resp_stall", {31'h0, stall_w[3]}, 32'h0);
    drive(1'b1, 4'h0, 32'h40, 32'h0);
    exp_q.push_back(32'h12345678);
    step();
    chk("w3_b2b_accept1", {31'h0, stall_w[3]}, 32'h1);
    idle_n(3);
    chk("w3_resp2_rvalid", {31'h0, rvalid_w[3]}, 32'h1);
    drive(1'b1, 4'h0, 32'h44, 32'h0);
    exp_q.push_back(32'hA5A5A5A5);
    step();
    chk("w3_b2b_accept2", {31'h0, stall_w[3]}, 32'h1);
    idle_n(5);
    chk("w3_queue_drained", exp_q.size(), 32'h0);
    idle_n(2);

    // WAIT=2: reset in the second BUSY cycle aborts the read but keeps memory.
    sel = 2;
    drive(1'b1, 4'hF, 32'h50, 32'hCAFEF00D);
    step();
    drive(1'b1, 4'h0, 32'h50, 32'h0);
    exp_q.push_back(32'hCAFEF00D);
    step();
    idle_n(4);
    chk("w2_first_read_drained", exp_q.size(), 32'h0);
    drive(1'b1, 4'h0, 32'h50, 32'h0);
    step();
    drive(1'b0, 4'h0, 32'h0, 32'h0);
    step();
    chk("w2_second_busy", {31'h0, stall_w[2]}, 32'h1);
    resetn = 1'b0;
    #1;
    chk("w2_rst_stall", {31'h0, stall_w[2]}, 32'h0);
    chk("w2_rst_rvalid", {31'h0, rvalid_w[2]}, 32'h0);
    chk("w2_rst_rdata", rdata_w[2], 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rv_before = rv_seen;
    idle_n(6);
    chk("w2_no_rvalid_after_abort", rv_seen - rv_before, 32'h0);
    drive(1'b1, 4'h0, 32'h53, 32'h0);
    exp_q.push_back(32'hCAFEF00D);
    step();
    idle_n(4);
    chk("w2_mem_kept_drained", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
